// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU: queues commands, issues one at a time, holds the accumulator.
// Optional divide-by-zero guard enabled by defining ALU_SEQ_DIV0_GUARD_EN.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
  output logic       bus_en,
  output logic [3:0] acc,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  logic [1:0]  state;
  logic [8:0]  fifo_mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [8:0]  head_p0;
  logic        div0;

  // Compare ops only report; they never disturb the accumulator.
  function automatic logic is_compare(input logic [3:0] op);
    return (op == 4'b1110) || (op == 4'b1111);
  endfunction

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign head_p0   = fifo_mem[rd_ptr[AW-1:0]];

  assign res_valid = (state == RESULT);
  assign bus_en    = res_valid;
  assign busy      = (state != IDLE) || !empty;

`ifdef ALU_SEQ_DIV0_GUARD_EN
  assign div0 = (alu_sel == 4'b0011) && (alu_b == 4'd0);
`else
  assign div0 = 1'b0;
`endif

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {cmd_load, cmd_op, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Stage boundary: head entry -> ALU inputs (IDLE), ALU output -> result (ISSUE)
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_p0[8]) begin
              acc <= head_p0[3:0];
            end else begin
              alu_a   <= acc;
              alu_b   <= head_p0[3:0];
              alu_sel <= head_p0[7:4];
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          res_data <= div0 ? 8'hFF : alu_result;
          res_err  <= div0;
          if (!is_compare(alu_sel) && !div0) acc <= alu_result[3:0];
          state <= RESULT;
        end
        RESULT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU on alu_a/alu_b/alu_sel.
// Expectations for the divide-by-zero case follow ALU_SEQ_DIV0_GUARD_EN.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [3:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
  logic       bus_en;
  logic [3:0] acc;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [12:0] exp_q [$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .bus_en(bus_en), .acc(acc), .busy(busy)
  );

  // ALU stand-in; divide by zero returns F0 so pass-through is visible
  logic [7:0] a8, b8;
  always_comb begin
    a8 = {4'b0, alu_a};
    b8 = {4'b0, alu_b};
    case (alu_sel)
      4'b0000: alu_result = a8 + b8;
      4'b0001: alu_result = a8 - b8;
      4'b0010: alu_result = a8 * b8;
      4'b0011: alu_result = (alu_b == 4'd0) ? 8'hF0 : a8 / b8;
      4'b1110: alu_result = {7'b0, alu_a > alu_b};
      4'b1111: alu_result = {7'b0, alu_a == alu_b};
      default: alu_result = {alu_a, alu_b};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each accepted result against the scoreboard head
  always @(negedge clk) begin
    if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {24'b0, res_data}, 32'hFFFF_FFFF);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("res_data", {24'b0, res_data}, {24'b0, e[12:5]});
        check("res_err", {31'b0, res_err}, {31'b0, e[4]});
        check("acc_after", {28'b0, acc}, {28'b0, e[3:0]});
        check("bus_en", {31'b0, bus_en}, 32'd1);
      end
    end
  end

  task automatic push(input logic l, input logic [3:0] op, input logic [3:0] d,
                      input bit has, input logic [7:0] ed, input logic ee, input logic [3:0] ea);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_load  = l;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (has) exp_q.push_back({ed, ee, ea});
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || res_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_bus_en", {31'b0, bus_en}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_res_data", {24'b0, res_data}, 32'd0);
    check("rst_res_err", {31'b0, res_err}, 32'd0);
    check("rst_acc", {28'b0, acc}, 32'd0);
    check("rst_alu_in", {20'b0, alu_a, alu_b, alu_sel}, 32'd0);

    // load 5, add 3 with latency and single-cycle bus_en
    res_ready = 1'b1;
    push(1'b1, 4'h0, 4'd5, 1'b0, 8'd0, 1'b0, 4'd0);
    repeat (3) @(negedge clk);
    check("load_acc", {28'b0, acc}, 32'd5);
    push(1'b0, 4'h0, 4'd3, 1'b1, 8'd8, 1'b0, 4'd8);
    @(negedge clk);
    check("lat_t0_valid", {31'b0, res_valid}, 32'd0);
    @(negedge clk);
    check("lat_t1_valid", {31'b0, res_valid}, 32'd0);
    check("lat_t1_alu_in", {20'b0, alu_a, alu_b, alu_sel}, {20'b0, 4'd5, 4'd3, 4'h0});
    @(negedge clk);
    check("lat_t2_valid", {31'b0, res_valid}, 32'd1);
    @(negedge clk);
    check("bus_en_one_cycle", {31'b0, bus_en}, 32'd0);

    // multiply overflow, equal compare, subtract
    push(1'b1, 4'h0, 4'd15, 1'b0, 8'd0, 1'b0, 4'd0);
    push(1'b0, 4'h2, 4'd15, 1'b1, 8'd225, 1'b0, 4'd1);
    wait_idle();
    push(1'b1, 4'h0, 4'd7, 1'b0, 8'd0, 1'b0, 4'd0);
    push(1'b0, 4'hF, 4'd7, 1'b1, 8'd1, 1'b0, 4'd7);
    push(1'b0, 4'h1, 4'd2, 1'b1, 8'd5, 1'b0, 4'd5);
    wait_idle();

    // backpressure: DEPTH+1 accepted pushes fill the FIFO
    @(negedge clk);
    res_ready = 1'b0;
    push(1'b0, 4'h0, 4'd1, 1'b1, 8'd6,  1'b0, 4'd6);
    push(1'b0, 4'h0, 4'd1, 1'b1, 8'd7,  1'b0, 4'd7);
    push(1'b0, 4'h0, 4'd1, 1'b1, 8'd8,  1'b0, 4'd8);
    push(1'b0, 4'h0, 4'd1, 1'b1, 8'd9,  1'b0, 4'd9);
    push(1'b0, 4'h0, 4'd1, 1'b1, 8'd10, 1'b0, 4'd10);
    @(negedge clk);
    check("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("hold_data_a", {24'b0, res_data}, 32'd6);
    repeat (3) @(negedge clk);
    check("hold_data_b", {24'b0, res_data}, 32'd6);
    check("hold_bus_en", {31'b0, bus_en}, 32'd1);
    res_ready = 1'b1;
    wait_idle();
    check("drain_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("drain_acc", {28'b0, acc}, 32'd10);

    // divide by zero, then normal divide
`ifdef ALU_SEQ_DIV0_GUARD_EN
    push(1'b0, 4'h3, 4'd0, 1'b1, 8'hFF, 1'b1, 4'd10);
`else
    push(1'b0, 4'h3, 4'd0, 1'b1, 8'hF0, 1'b0, 4'd0);
`endif
    wait_idle();
    push(1'b1, 4'h0, 4'd9, 1'b0, 8'd0, 1'b0, 4'd0);
    push(1'b0, 4'h3, 4'd2, 1'b1, 8'd4, 1'b0, 4'd4);
    wait_idle();

    // reset while holding a result with two entries queued
    @(negedge clk);
    res_ready = 1'b0;
    push(1'b0, 4'h0, 4'd1, 1'b0, 8'd0, 1'b0, 4'd0);
    push(1'b0, 4'h0, 4'd1, 1'b0, 8'd0, 1'b0, 4'd0);
    push(1'b0, 4'h0, 4'd1, 1'b0, 8'd0, 1'b0, 4'd0);
    begin
      int n = 0;
      while (!res_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("pre_rst_valid", {31'b0, res_valid}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("mid_rst_acc", {28'b0, acc}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_res_data", {24'b0, res_data}, 32'd0);
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    res_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
